booth_wallace_mult_pipe: RTL

- Parametrised, pipelined successor to the team's 16-bit combinational radix-4 Booth / Wallace-tree multiplier.
- Multiplies two WIDTH-bit operands, each op selecting signed or unsigned, with a 3-stage registered pipeline and valid/ready handshakes on both sides.
- Sits between an operand source (ALU/DSP issue logic) and a result consumer that may stall; one multiply accepted per clock when unstalled.

---
 rtl/booth_wallace_mult_pipe.sv | 139 +++++++++++++
 1 files changed

// File: rtl/booth_wallace_mult_pipe.sv
// Pipelined radix-4 Booth / Wallace-tree multiplier (S1 recode+PP, S2 CSA tree, S3 CPA), valid/ready on both sides.
// Optional BWM_ACCUMULATE_EN adds in_acc: out_p = product + (acc ? previous out_p : 0).
module booth_wallace_mult_pipe #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
`ifdef BWM_ACCUMULATE_EN
    input  logic               in_acc,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p
);
    localparam int P   = 2 * WIDTH;
    localparam int EW  = WIDTH + 2;
    localparam int NPP = WIDTH / 2 + 1;
    localparam int NR  = NPP + 1;      // partial products plus one row of hot bits
    localparam int NA  = NR + 2;       // padding so the 3:2 grouping never indexes past the end

    logic [3:1] vld_pipe;
    logic       advance;

    assign advance   = !vld_pipe[3] | out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe[3];

    // ---------------- S1: Booth recode and partial products ----------------
    logic [EW-1:0] xe, ye;
    logic [EW:0]   xb;
    logic [P-1:0]  ys, mag;
    logic [2:0]    trip;
    logic          neg;
    logic [P-1:0]  pp_d [NR];
    logic [P-1:0]  pp_q [NR];

    always_comb begin
        xe   = {{2{in_signed & in_x[WIDTH-1]}}, in_x};
        ye   = {{2{in_signed & in_y[WIDTH-1]}}, in_y};
        xb   = {xe, 1'b0};
        ys   = {{(P-EW){ye[EW-1]}}, ye};
        trip = '0;
        mag  = '0;
        neg  = 1'b0;
        pp_d = '{default: '0};
        for (int i = 0; i < NPP; i++) begin
            trip = xb[2*i+2 -: 3];
            case (trip)
                3'b001, 3'b010, 3'b101, 3'b110: mag = ys;
                3'b011, 3'b100:                 mag = ys << 1;
                default:                        mag = '0;
            endcase
            // 111 is a zero digit; treat it as +0 so it needs no hot bit
            neg = trip[2] & ~(trip[1] & trip[0]);
            pp_d[i]          = (neg ? ~mag : mag) << (2 * i);
            pp_d[NR-1][2*i]  = neg;
        end
    end

    // ---------------- S2: Wallace 3:2 reduction to two rows ----------------
    logic [P-1:0] lvl [NA];
    logic [P-1:0] nxt [NA];
    logic [P-1:0] sum_d, car_d, sum_q, car_q;
    int           n, m;

    always_comb begin
        lvl = '{default: '0};
        nxt = '{default: '0};
        for (int r = 0; r < NR; r++) lvl[r] = pp_q[r];
        n = NR;
        m = 0;
        for (int lv = 0; lv < NR; lv++) begin
            if (n > 2) begin
                nxt = '{default: '0};
                m   = 0;
                for (int g = 0; g < NA / 3; g++) begin
                    if (3*g + 2 < n) begin
                        nxt[m]   = lvl[3*g] ^ lvl[3*g+1] ^ lvl[3*g+2];
                        nxt[m+1] = ((lvl[3*g] & lvl[3*g+1]) | (lvl[3*g] & lvl[3*g+2]) |
                                    (lvl[3*g+1] & lvl[3*g+2])) << 1;
                        m = m + 2;
                    end else if (3*g < n) begin
                        nxt[m] = lvl[3*g];
                        m = m + 1;
                        if (3*g + 1 < n) begin
                            nxt[m] = lvl[3*g+1];
                            m = m + 1;
                        end
                    end
                end
                lvl = nxt;
                n   = m;
            end
        end
        sum_d = lvl[0];
        car_d = lvl[1];
    end

    // ---------------- pipeline registers ----------------
`ifdef BWM_ACCUMULATE_EN
    logic acc1, acc2;
    always_ff @(posedge clk) begin
        if (advance) begin
            acc1 <= in_acc;
            acc2 <= acc1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (advance) begin
            pp_q  <= pp_d;
            sum_q <= sum_d;
            car_q <= car_d;
        end
    end

    // out_p only loads on a valid op, so it doubles as the accumulator state
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            out_p    <= '0;
        end else if (advance) begin
            vld_pipe <= {vld_pipe[2:1], in_valid};
            if (vld_pipe[2]) begin
`ifdef BWM_ACCUMULATE_EN
                out_p <= sum_q + car_q + (acc2 ? out_p : '0);
`else
                out_p <= sum_q + car_q;
`endif
            end
        end
    end
endmodule
